// File: rtl/pipe_hazard_unit.sv
// Decode-stage hazard/issue controller: shift-register scoreboard of in-flight
// register and flag writers, RAW stall, taken-branch squash window, stall counter.
module pipe_hazard_unit #(
    parameter int DEPTH        = 3,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic             dec_uses_x,
    input  logic             dec_uses_y,
    input  logic [4:0]       dec_x_addr,
    input  logic [4:0]       dec_y_addr,
    input  logic             dec_rf_wr,
    input  logic [4:0]       dec_wb_addr,
    input  logic             dec_flag_rd,
    input  logic             dec_flag_wr,
    input  logic             ex_branch_taken,
    input  logic             stat_clr,
    output logic             nop,
    output logic             stall,
    output logic             flush_if,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    localparam bit         FLUSH_EN  = (FLUSH_CYCLES > 0);
    localparam logic [2:0] FCNT_INIT = 3'(FLUSH_EN ? FLUSH_CYCLES - 1 : 0);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_fcnt;
    logic [2:0]       w_fcnt_nxt;

    logic             r_sb_v    [DEPTH];
    logic [4:0]       r_sb_addr [DEPTH];
    logic             r_sb_f    [DEPTH];

    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_x_any;
    logic             w_y_any;
    logic             w_f_any;
    logic             w_raw;
    logic             w_kill;
    logic             w_issue;

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_x_any = 1'b0;
        w_y_any = 1'b0;
        w_f_any = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_x_any = w_x_any | (r_sb_v[i] & (r_sb_addr[i] == dec_x_addr));
            w_y_any = w_y_any | (r_sb_v[i] & (r_sb_addr[i] == dec_y_addr));
            w_f_any = w_f_any | r_sb_f[i];
        end
    end

    assign w_raw = dec_valid & ((dec_uses_x & w_x_any) |
                                (dec_uses_y & w_y_any) |
                                (dec_flag_rd & w_f_any));

    // A taken branch wins over a hazard: the stalled instruction is on the wrong path.
    assign w_kill   = ex_branch_taken | (r_state == ST_FLUSH);
    assign nop      = ~rst | ~dec_valid | w_kill | w_raw;
    assign stall    = rst & w_raw & ~w_kill;
    assign flush_if = rst & w_kill;
    assign w_issue  = dec_valid & ~nop;

    // NOTE: the scoreboard is a handful of flops, not a RAM, so it is reset;
    // stale valid bits after reset would cause phantom stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_sb_v[i]    <= 1'b0;
                r_sb_addr[i] <= 5'd0;
                r_sb_f[i]    <= 1'b0;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage read the pre-edge value, giving a true shift.
            r_sb_v[0]    <= w_issue & dec_rf_wr;
            r_sb_addr[0] <= dec_wb_addr;
            r_sb_f[0]    <= w_issue & dec_flag_wr;
            for (int i = 1; i < DEPTH; i++) begin
                r_sb_v[i]    <= r_sb_v[i-1];
                r_sb_addr[i] <= r_sb_addr[i-1];
                r_sb_f[i]    <= r_sb_f[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_RUN;
            r_fcnt  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    // A new taken branch restarts the squash window even when already flushing.
    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        if (ex_branch_taken && FLUSH_EN) begin
            w_state_nxt = ST_FLUSH;
            w_fcnt_nxt  = FCNT_INIT;
        end else if (r_state == ST_FLUSH) begin
            if (r_fcnt == 3'd0) begin
                w_state_nxt = ST_RUN;
            end else begin
                w_fcnt_nxt = r_fcnt - 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (stat_clr) begin
            r_stall_cnt <= '0;
        end else if (stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed, table-driven bench for pipe_hazard_unit (DEPTH=3, FLUSH_CYCLES=1, CNT_W=4).
module tb_pipe_hazard_unit;

    typedef struct {
        logic       rst, valid, ux;
        logic [4:0] xa;
        logic       uy;
        logic [4:0] ya;
        logic       rfwr;
        logic [4:0] wba;
        logic       frd, fwr, br, clr;
        logic       e_nop, e_stall, e_flush;
        int         e_cnt;   // -1: count not yet defined
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       dec_valid, dec_uses_x, dec_uses_y;
    logic [4:0] dec_x_addr, dec_y_addr, dec_wb_addr;
    logic       dec_rf_wr, dec_flag_rd, dec_flag_wr;
    logic       ex_branch_taken, stat_clr;
    logic       nop, stall, flush_if;
    logic [3:0] stall_count;

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs[$];

    pipe_hazard_unit #(.DEPTH(3), .FLUSH_CYCLES(1), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_uses_x(dec_uses_x), .dec_uses_y(dec_uses_y),
        .dec_x_addr(dec_x_addr), .dec_y_addr(dec_y_addr),
        .dec_rf_wr(dec_rf_wr), .dec_wb_addr(dec_wb_addr),
        .dec_flag_rd(dec_flag_rd), .dec_flag_wr(dec_flag_wr),
        .ex_branch_taken(ex_branch_taken), .stat_clr(stat_clr),
        .nop(nop), .stall(stall), .flush_if(flush_if), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, v, ux, input logic [4:0] xa,
                                input logic uy, input logic [4:0] ya,
                                input logic rw, input logic [4:0] wa,
                                input logic frd, fwr, br, clr,
                                input logic en, es, ef, input int ec);
        vec_t t;
        t.rst = r; t.valid = v; t.ux = ux; t.xa = xa; t.uy = uy; t.ya = ya;
        t.rfwr = rw; t.wba = wa; t.frd = frd; t.fwr = fwr; t.br = br; t.clr = clr;
        t.e_nop = en; t.e_stall = es; t.e_flush = ef; t.e_cnt = ec;
        return t;
    endfunction

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rst = t.rst; dec_valid = t.valid;
        dec_uses_x = t.ux; dec_x_addr = t.xa; dec_uses_y = t.uy; dec_y_addr = t.ya;
        dec_rf_wr = t.rfwr; dec_wb_addr = t.wba;
        dec_flag_rd = t.frd; dec_flag_wr = t.fwr;
        ex_branch_taken = t.br; stat_clr = t.clr;
    endtask

    // Called at posedge+1; samples mid-cycle, then advances one clock.
    task automatic apply(input int idx, input vec_t t);
        drive(t);
        #2;
        check("nop", idx, int'(nop), int'(t.e_nop));
        check("stall", idx, int'(stall), int'(t.e_stall));
        check("flush_if", idx, int'(flush_if), int'(t.e_flush));
        if (t.e_cnt >= 0) check("stall_count", idx, int'(stall_count), t.e_cnt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   exp_cnt;
        logic exp_s;

        //                r  v  ux xa  uy ya  rw wa  frd fwr br clr  nop st fl cnt
        // reset
        vecs.push_back(mk(0, 0, 0, 0,  0, 0,  0, 0,  0,  0,  0, 0,   1, 0, 0, -1));
        vecs.push_back(mk(0, 1, 1, 5,  0, 0,  1, 5,  0,  0,  0, 0,   1, 0, 0, 0));
        // back-to-back RAW on r5: three stall cycles
        vecs.push_back(mk(1, 1, 0, 0,  0, 0,  1, 5,  0,  0,  0, 0,   0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 5,  0, 0,  1, 9,  0,  0,  0, 0,   1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 5,  0, 0,  1, 9,  0,  0,  0, 0,   1, 1, 0, 1));
        vecs.push_back(mk(1, 1, 1, 5,  0, 0,  1, 9,  0,  0,  0, 0,   1, 1, 0, 2));
        vecs.push_back(mk(1, 1, 1, 5,  0, 0,  1, 9,  0,  0,  0, 0,   0, 0, 0, 3));
        // independent stream, then r9 seen in the last slot, then retired
        vecs.push_back(mk(1, 1, 1, 6,  1, 7,  1, 5,  0,  0,  0, 0,   0, 0, 0, 3));
        vecs.push_back(mk(1, 1, 1, 6,  1, 7,  1, 5,  0,  0,  0, 0,   0, 0, 0, 3));
        vecs.push_back(mk(1, 1, 0, 0,  1, 9,  0, 0,  0,  0,  0, 0,   1, 1, 0, 3));
        vecs.push_back(mk(1, 1, 0, 5,  1, 9,  0, 0,  0,  0,  0, 0,   0, 0, 0, 4));
        // flag hazard ADD -> BRCC
        vecs.push_back(mk(1, 1, 0, 0,  0, 0,  0, 0,  0,  1,  0, 0,   0, 0, 0, 4));
        vecs.push_back(mk(1, 1, 0, 0,  0, 0,  0, 0,  1,  0,  0, 0,   1, 1, 0, 4));
        vecs.push_back(mk(1, 1, 0, 0,  0, 0,  0, 0,  1,  0,  0, 0,   1, 1, 0, 5));
        vecs.push_back(mk(1, 1, 0, 0,  0, 0,  0, 0,  1,  0,  0, 0,   1, 1, 0, 6));
        vecs.push_back(mk(1, 1, 0, 0,  0, 0,  0, 0,  1,  0,  0, 0,   0, 0, 0, 7));
        // same without flag read; invalid decode never stalls
        vecs.push_back(mk(1, 1, 0, 0,  0, 0,  0, 0,  0,  1,  0, 0,   0, 0, 0, 7));
        vecs.push_back(mk(1, 1, 0, 0,  0, 0,  0, 0,  0,  0,  0, 0,   0, 0, 0, 7));
        vecs.push_back(mk(1, 0, 0, 0,  0, 0,  0, 0,  1,  0,  0, 0,   1, 0, 0, 7));
        vecs.push_back(mk(1, 0, 0, 0,  0, 0,  0, 0,  0,  0,  0, 0,   1, 0, 0, 7));
        // taken branch overrides RAW; squashed r12 never enters the scoreboard
        vecs.push_back(mk(1, 1, 0, 0,  0, 0,  1, 3,  0,  0,  0, 0,   0, 0, 0, 7));
        vecs.push_back(mk(1, 1, 1, 3,  0, 0,  1, 12, 0,  0,  1, 0,   1, 0, 1, 7));
        vecs.push_back(mk(1, 1, 1, 3,  0, 0,  0, 0,  0,  0,  0, 0,   1, 0, 1, 7));
        vecs.push_back(mk(1, 1, 1, 3,  0, 0,  0, 0,  0,  0,  0, 0,   1, 1, 0, 7));
        vecs.push_back(mk(1, 1, 1, 3,  1, 12, 0, 0,  0,  0,  0, 0,   0, 0, 0, 8));
        // second pulse during FLUSH extends the window
        vecs.push_back(mk(1, 1, 0, 0,  0, 0,  0, 0,  0,  0,  1, 0,   1, 0, 1, 8));
        vecs.push_back(mk(1, 1, 0, 0,  0, 0,  0, 0,  0,  0,  1, 0,   1, 0, 1, 8));
        vecs.push_back(mk(1, 1, 0, 0,  0, 0,  0, 0,  0,  0,  0, 0,   1, 0, 1, 8));
        vecs.push_back(mk(1, 1, 0, 0,  0, 0,  0, 0,  0,  0,  0, 0,   0, 0, 0, 8));
        // reset mid-stall, then mid-FLUSH
        vecs.push_back(mk(1, 1, 0, 0,  0, 0,  1, 20, 0,  0,  0, 0,   0, 0, 0, 8));
        vecs.push_back(mk(1, 1, 1, 20, 0, 0,  0, 0,  0,  0,  0, 0,   1, 1, 0, 8));
        vecs.push_back(mk(0, 1, 1, 20, 0, 0,  0, 0,  0,  0,  0, 0,   1, 0, 0, 9));
        vecs.push_back(mk(1, 1, 1, 20, 0, 0,  0, 0,  0,  0,  0, 0,   0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0,  0, 0,  0, 0,  0,  0,  1, 0,   1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0,  0, 0,  0,  0,  0, 0,   1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0,  0, 0,  0, 0,  0,  0,  0, 0,   0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0,  0, 0,  1, 1,  0,  0,  0, 0,   0, 0, 0, 0));

        drive(vecs[0]);
        @(posedge clk);
        #1;
        foreach (vecs[i]) apply(i, vecs[i]);

        // Saturation: read+write r1 every cycle -> 3 stalls then one issue, repeating.
        exp_cnt = 0;
        for (int i = 0; i < 28; i++) begin
            exp_s = ((i % 4) != 3);
            apply(100 + i, mk(1, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, exp_s, exp_s, 0, exp_cnt));
            if (exp_s) exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
        end
        // stat_clr coincident with a stall wins over the increment
        apply(200, mk(1, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 1, 1, 1, 0, 15));
        apply(201, mk(1, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0));
        apply(202, mk(1, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Decode-stage hazard and issue controller that produces the `nop` qualifier consumed by the ID/EX control-vector pipeline register.
- Keeps a shift-register scoreboard of in-flight register-file and flag writers, and stalls decode on RAW hazards.
- Squashes wrong-path instructions after a taken branch is resolved in execute.
- Also drives the fetch-side stall and flush and keeps a saturating stall-cycle counter for performance debug.

Parameters:
- DEPTH, 3, pipeline stages between the ID/EX register and register-file writeback (scoreboard length, >=1).
- FLUSH_CYCLES, 1, extra cycles `nop` stays high after the taken-branch cycle (0..7).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset.
- dec_valid  in  1  decode holds a real instruction.
- dec_uses_x  in  1  instruction reads register X.
- dec_uses_y  in  1  instruction reads register Y.
- dec_x_addr  in  5  register X address.
- dec_y_addr  in  5  register Y address.
- dec_rf_wr  in  1  instruction writes the register file.
- dec_wb_addr  in  5  destination register.
- dec_flag_rd  in  1  instruction reads C/Z (conditional branch, ADDC, SUBC, ...).
- dec_flag_wr  in  1  instruction writes C or Z.
- ex_branch_taken  in  1  execute resolved a taken branch this cycle.
- stat_clr  in  1  clear stall counter.
- nop  out  1  zero the control vector entering ID/EX.
- stall  out  1  hold PC and the IF/ID register.
- flush_if  out  1  invalidate the IF/ID register.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Scoreboard: entries sb[0..DEPTH-1], each {v, addr[4:0], f}.
  - Each posedge: sb[i+1] <= sb[i].
  - sb[0] <= {issue & dec_rf_wr, dec_wb_addr, issue & dec_flag_wr}, where issue = dec_valid & ~nop.
  - sb[DEPTH-1] is discarded on shift; its write lands that edge.
- Match rules:
  - x_hit = dec_uses_x & any(sb[i].v & sb[i].addr==dec_x_addr); y_hit likewise.
  - f_hit = dec_flag_rd & any(sb[i].f).
  - Register 0 is ordinary; it is not hardwired.
- raw = dec_valid & (x_hit | y_hit | f_hit).
- FSM states RUN and FLUSH, with counter fcnt of width 3.
  - Any state, ex_branch_taken=1 and FLUSH_CYCLES>0: go to FLUSH, fcnt <= FLUSH_CYCLES-1. This also restarts the count if already in FLUSH.
  - FLUSH, no new taken branch: if fcnt==0 go to RUN, else fcnt <= fcnt-1.
  - FLUSH_CYCLES=0: FSM never leaves RUN.
- Outputs (combinational from state and inputs):
  - kill = ex_branch_taken | (state==FLUSH).
  - nop = ~dec_valid | kill | raw.
  - stall = raw & ~kill. A branch kill overrides a hazard; the stalled instruction is wrong-path.
  - flush_if = kill.
- Stall counter:
  - stat_clr=1: counter <= 0, which has priority over increment.
  - Otherwise, if stall=1 and counter != all-ones: counter+1.
  - Holds at all-ones (saturates).
- Reset (rst=0 at posedge):
  - All sb entries invalid, state RUN, fcnt 0, stall_count 0.
  - While rst=0 the outputs are forced: nop=1, stall=0, flush_if=0.
  - Reset mid-FLUSH or mid-stall aborts it; the first cycle after release behaves as RUN with an empty scoreboard.
- Latency:
  - Hazard detection is zero-cycle (same cycle as decode).
  - A producer issued at edge T clears from the scoreboard after edge T+DEPTH. A dependent consumer stalls exactly DEPTH cycles when back-to-back.

Test Plan:
- Back-to-back RAW, DEPTH=3: issue write r5, next cycle read X=r5 -> stall=1 and nop=1 for 3 cycles, then issue with stall=0; stall_count=3.
- Independent stream: write r5, read r6/r7 each cycle -> stall never asserted, nop=0 every cycle, scoreboard entries retire after 3 edges.
- Flag hazard: ADD (flag_wr) then BRCC (flag_rd) -> stall 3 cycles; the same sequence with dec_flag_rd=0 -> no stall.
- Taken branch, FLUSH_CYCLES=1: ex_branch_taken pulse while decode has a RAW hazard -> nop=1, flush_if=1, stall=0 that cycle and the next, no scoreboard insert; second pulse during FLUSH extends the window by one.
- Reset mid-stall: assert rst=0 during a stall -> next cycle nop=1, stall=0, stall_count=0; after release a read of the earlier destination issues with no stall.
- Saturation, CNT_W=4: 20 stall cycles -> stall_count=15 and holds; stat_clr coincident with stall -> 0.
